gate_vector_checker: RTL and testbench

// - Self-test stage around the two-input gate block: drives in1/in2 through all 4 input vectors.
// - Samples the 8-bit result vectors from the gate-level, dataflow and behavioural styles.
// - Compares them against a golden truth table and reports mismatch count, first failure, pass/done.
// - Sits directly upstream (operand source) and downstream (result consumer) of the gate block.

---
 rtl/gate_vector_checker_pkg.sv | 50 +++++
 rtl/gate_vector_checker_golden.sv | 20 ++
 rtl/gate_vector_checker.sv | 119 +++++++++++
 tb/tb_gate_vector_checker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_vector_checker_pkg.sv
// Shared definitions for the gate-block self-test: result bit positions,
// FSM encoding, first-error record and the mismatch reduction helpers.
package gate_vector_checker_pkg;

   localparam int RES_W       = 8;
   localparam int STYLE_COUNT = 3;
   localparam int MIS_W       = RES_W * STYLE_COUNT;

   localparam int BIT_AND     = 0;
   localparam int BIT_OR      = 1;
   localparam int BIT_XOR     = 2;
   localparam int BIT_NAND    = 3;
   localparam int BIT_NOR     = 4;
   localparam int BIT_XNOR    = 5;
   localparam int BIT_NOT_IN1 = 6;
   localparam int BIT_NOT_IN2 = 7;

   localparam logic [1:0] LAST_VEC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   typedef struct packed {
      logic [1:0] vec;
      logic [1:0] style;
      logic [2:0] func;
   } first_err_t;

   function automatic logic [4:0] popcount_mis(input logic [MIS_W-1:0] m);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < MIS_W; i++) n = n + {4'd0, m[i]};
      return n;
   endfunction

   // Index of the lowest set bit; the style sits in bits [4:3], the function in [2:0].
   function automatic logic [4:0] lowest_set(input logic [MIS_W-1:0] m);
      logic [4:0] idx;
      idx = '0;
      for (int i = MIS_W - 1; i >= 0; i--) begin
         if (m[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/gate_vector_checker_golden.sv
// Golden truth table for the two-input gate block: one operand pair in,
// the eight expected function results out in the shared bit order.
module gate_golden
   import gate_vector_checker_pkg::*;
(
   input  logic             in1,
   input  logic             in2,
   output logic [RES_W-1:0] golden
);

   assign golden[BIT_AND]     = in1 & in2;
   assign golden[BIT_OR]      = in1 | in2;
   assign golden[BIT_XOR]     = in1 ^ in2;
   assign golden[BIT_NAND]    = ~(in1 & in2);
   assign golden[BIT_NOR]     = ~(in1 | in2);
   assign golden[BIT_XNOR]    = ~(in1 ^ in2);
   assign golden[BIT_NOT_IN1] = ~in1;
   assign golden[BIT_NOT_IN2] = ~in2;

endmodule

// File: rtl/gate_vector_checker.sv
// Self-test stage: steps the gate block through all four operand pairs,
// compares the three result styles to the golden table and records errors.
module gate_vector_checker
   import gate_vector_checker_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [RES_W-1:0] res_gate,
   input  logic [RES_W-1:0] res_flow,
   input  logic [RES_W-1:0] res_beh,
   output logic             in1,
   output logic             in2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [6:0]       err_count,
   output logic             err_valid,
   output logic [1:0]       first_vec,
   output logic [1:0]       first_style,
   output logic [2:0]       first_func
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [1:0]       vec_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       drive_q;
   logic [6:0]       err_count_q;
   logic             err_valid_q;
   first_err_t       first_q;

   logic [RES_W-1:0] golden;
   logic [MIS_W-1:0] mismatch;
   logic [4:0]       mis_count;
   logic [4:0]       mis_idx;
   logic             start_run;

   gate_golden u_golden (
      .in1    (vec_q[1]),
      .in2    (vec_q[0]),
      .golden (golden)
   );

   assign mismatch  = {res_beh, res_flow, res_gate} ^ {STYLE_COUNT{golden}};
   assign mis_count = popcount_mis(mismatch);
   assign mis_idx   = lowest_set(mismatch);
   assign start_run = start && (state_q == ST_IDLE || state_q == ST_DONE);

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_DRIVE;
         ST_DRIVE:         if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
         ST_SAMPLE:        state_d = (vec_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
      done = (state_q == ST_DONE);
      pass = (state_q == ST_DONE) && (err_count_q == '0);
   end

   // Counters, operand drive and error bookkeeping; results are only looked at in SAMPLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q       <= '0;
         cnt_q       <= '0;
         drive_q     <= '0;
         err_count_q <= '0;
         err_valid_q <= 1'b0;
         first_q     <= '0;
      end else if (start_run) begin
         vec_q       <= '0;
         cnt_q       <= '0;
         drive_q     <= '0;
         err_count_q <= '0;
         err_valid_q <= 1'b0;
         first_q     <= '0;
      end else if (state_q == ST_DRIVE) begin
         cnt_q <= cnt_q + 1'b1;
      end else if (state_q == ST_SAMPLE) begin
         err_count_q <= err_count_q + {2'b00, mis_count};
         if (!err_valid_q && (mismatch != '0)) begin
            err_valid_q   <= 1'b1;
            first_q.vec   <= vec_q;
            first_q.style <= mis_idx[4:3];
            first_q.func  <= mis_idx[2:0];
         end
         if (vec_q != LAST_VEC) begin
            vec_q   <= vec_q + 2'd1;
            drive_q <= vec_q + 2'd1;
            cnt_q   <= '0;
         end
      end
   end

   assign in1         = drive_q[1];
   assign in2         = drive_q[0];
   assign err_count   = err_count_q;
   assign err_valid   = err_valid_q;
   assign first_vec   = first_q.vec;
   assign first_style = first_q.style;
   assign first_func  = first_q.func;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a behavioural gate block (with selectable faults)
// answers the operands, and an arithmetic reference predicts every reported result.
module tb_gate_vector_checker;

   localparam int MODE_OK       = 0;
   localparam int MODE_BEH_NOR  = 1;
   localparam int MODE_GATE0    = 2;
   localparam int MODE_RAND     = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  res_gate, res_flow, res_beh;
   logic        in1, in2, busy, done, pass, err_valid;
   logic [6:0]  err_count;
   logic [1:0]  first_vec, first_style;
   logic [2:0]  first_func;

   logic [7:0]  res_gate_s1, res_flow_s1, res_beh_s1;
   logic        in1_s1, in2_s1, busy_s1, done_s1, pass_s1, err_valid_s1;
   logic [6:0]  err_count_s1;
   logic [1:0]  first_vec_s1, first_style_s1;
   logic [2:0]  first_func_s1;

   int          mode = MODE_OK;
   logic [95:0] mask_bits = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   // Expected results from counting how many operands are 1.
   function automatic logic [7:0] ref_golden(input logic a, input logic b);
      int s;
      logic [7:0] r;
      s = int'(a) + int'(b);
      r[0] = (s == 2); r[1] = (s >= 1); r[2] = (s == 1); r[3] = (s != 2);
      r[4] = (s == 0); r[5] = (s != 1); r[6] = (a == 1'b0); r[7] = (b == 1'b0);
      return r;
   endfunction

   // What the (possibly faulty) gate block returns for one style and operand pair.
   function automatic logic [7:0] block_model(input int m, input logic [95:0] mb,
                                              input int style, input logic [1:0] v);
      logic [7:0] r;
      r = ref_golden(v[1], v[0]);
      case (m)
         MODE_BEH_NOR: if (style == 2) r[4] = r[3];
         MODE_GATE0:   if (style == 0) r = 8'h00;
         MODE_RAND:    r = r ^ mb[style*32 + int'(v)*8 +: 8];
         default: ;
      endcase
      return r;
   endfunction

   assign res_gate = block_model(mode, mask_bits, 0, {in1, in2});
   assign res_flow = block_model(mode, mask_bits, 1, {in1, in2});
   assign res_beh  = block_model(mode, mask_bits, 2, {in1, in2});

   assign res_gate_s1 = ref_golden(in1_s1, in2_s1);
   assign res_flow_s1 = ref_golden(in1_s1, in2_s1);
   assign res_beh_s1  = ref_golden(in1_s1, in2_s1);

   gate_vector_checker #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start),
      .res_gate(res_gate), .res_flow(res_flow), .res_beh(res_beh),
      .in1(in1), .in2(in2), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .err_valid(err_valid),
      .first_vec(first_vec), .first_style(first_style), .first_func(first_func)
   );

   gate_vector_checker #(.SETTLE_CYCLES(1)) dut_s1 (
      .clk(clk), .rst(rst), .start(start),
      .res_gate(res_gate_s1), .res_flow(res_flow_s1), .res_beh(res_beh_s1),
      .in1(in1_s1), .in2(in2_s1), .busy(busy_s1), .done(done_s1), .pass(pass_s1),
      .err_count(err_count_s1), .err_valid(err_valid_s1),
      .first_vec(first_vec_s1), .first_style(first_style_s1), .first_func(first_func_s1)
   );

   // Walk vectors in time order, then style, then bit, as a whole-run reference.
   task automatic compute_expect(output int cnt, output bit has_err, output logic [1:0] fv,
                                 output logic [1:0] fs, output logic [2:0] ff);
      logic [7:0] diff;
      cnt = 0; has_err = 1'b0; fv = '0; fs = '0; ff = '0;
      for (int v = 0; v < 4; v++) begin
         for (int s = 0; s < 3; s++) begin
            diff = block_model(mode, mask_bits, s, 2'(v)) ^ ref_golden(v[1], v[0]);
            for (int b = 0; b < 8; b++) begin
               if (diff[b]) begin
                  cnt++;
                  if (!has_err) begin
                     has_err = 1'b1; fv = 2'(v); fs = 2'(s); ff = 3'(b);
                  end
               end
            end
         end
      end
   endtask

   task automatic run_and_check(input string name, input bit hold);
      int exp_cnt;
      bit exp_err;
      logic [1:0] fv, fs;
      logic [2:0] ff;
      int lat;
      logic [1:0] seq[$];
      compute_expect(exp_cnt, exp_err, fv, fs, ff);
      lat = -1;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1;
      if (busy) seq.push_back({in1, in2});
      @(negedge clk) if (!hold) start = 1'b0;
      for (int k = 1; k <= 60 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (busy && (seq.size() == 0 || seq[$] != {in1, in2})) seq.push_back({in1, in2});
         if (done) lat = k;
      end
      n_checks++;
      if (lat != 12) begin n_fail++; $display("FAIL %s done_latency: got %0d expected 12", name, lat); end
      n_checks++;
      if (seq.size() != 4) begin
         n_fail++; $display("FAIL %s vector_steps: got %0d steps expected 4", name, seq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (seq[i] !== 2'(i)) begin
               n_fail++; $display("FAIL %s vector_%0d: got %b expected %b", name, i, seq[i], 2'(i));
            end
         end
      end
      n_checks++;
      if (err_count !== 7'(exp_cnt)) begin
         n_fail++; $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_cnt);
      end
      n_checks++;
      if ({busy, pass, err_valid} !== {1'b0, exp_cnt == 0, exp_err}) begin
         n_fail++; $display("FAIL %s busy_pass_valid: got %b expected %b", name,
                            {busy, pass, err_valid}, {1'b0, exp_cnt == 0, exp_err});
      end
      n_checks++;
      if ({first_vec, first_style, first_func} !== {fv, fs, ff}) begin
         n_fail++; $display("FAIL %s first_error: got vec=%0d style=%0d func=%0d expected vec=%0d style=%0d func=%0d",
                            name, first_vec, first_style, first_func, fv, fs, ff);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({in1, in2, busy, done, pass, err_valid} !== 6'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000000", {in1, in2, busy, done, pass, err_valid});
      end
      n_checks++;
      if (err_count !== 7'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
      n_checks++;
      if ({first_vec, first_style, first_func} !== 7'd0) begin
         n_fail++; $display("FAIL reset_first: got %b expected 0", {first_vec, first_style, first_func});
      end
      n_checks++;
      if ({in1_s1, in2_s1, busy_s1, done_s1, err_count_s1} !== 11'd0) begin
         n_fail++; $display("FAIL reset_s1: got %b expected 0", {in1_s1, in2_s1, busy_s1, done_s1, err_count_s1});
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_clean();
      mode = MODE_OK;
      run_and_check("clean", 1'b0);
   endtask

   task automatic test_beh_nor();
      mode = MODE_BEH_NOR;
      run_and_check("beh_nor", 1'b0);
      n_checks++;
      if ({err_count, first_vec, first_style, first_func, pass} !== {7'd2, 2'd1, 2'd2, 3'd4, 1'b0}) begin
         n_fail++; $display("FAIL beh_nor_summary: got cnt=%0d vec=%0d style=%0d func=%0d pass=%b expected 2 1 2 4 0",
                            err_count, first_vec, first_style, first_func, pass);
      end
   endtask

   task automatic test_gate_zero();
      mode = MODE_GATE0;
      run_and_check("gate_zero", 1'b0);
      n_checks++;
      if ({err_count, first_vec, first_style, first_func} !== {7'd16, 2'd0, 2'd0, 3'd3}) begin
         n_fail++; $display("FAIL gate_zero_summary: got cnt=%0d vec=%0d style=%0d func=%0d expected 16 0 0 3",
                            err_count, first_vec, first_style, first_func);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         @(negedge clk);
         mode = MODE_RAND;
         for (int k = 0; k < 12; k++) begin
            mask_bits[k*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
         end
         run_and_check($sformatf("random_%0d", it), 1'b0);
      end
   endtask

   // Start stays high: the running pass ignores it, DONE restarts immediately.
   task automatic test_start_held();
      int lat;
      mode = MODE_GATE0;
      run_and_check("start_held", 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if ({done, busy, err_count, err_valid} !== {1'b0, 1'b1, 7'd0, 1'b0}) begin
         n_fail++; $display("FAIL held_restart: got done=%b busy=%b cnt=%0d valid=%b expected 0 1 0 0",
                            done, busy, err_count, err_valid);
      end
      @(negedge clk) start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 30 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (done) lat = k;
      end
      n_checks++;
      if (lat < 0 || err_count !== 7'd16) begin
         n_fail++; $display("FAIL held_second_run: got lat=%0d cnt=%0d expected done with 16", lat, err_count);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      mode = MODE_GATE0;
      seen = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge clk); #1;
         if (busy && in1 && !in2) seen = 1'b1;
      end
      n_checks++;
      if (!seen || err_count !== 7'd9) begin
         n_fail++; $display("FAIL pre_reset: got seen=%b cnt=%0d expected vec 2 with 9", seen, err_count);
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done, in1, in2, err_count, err_valid} !== 12'd0) begin
         n_fail++; $display("FAIL mid_reset: got busy=%b done=%b in=%b%b cnt=%0d valid=%b expected all 0",
                            busy, done, in1, in2, err_count, err_valid);
      end
      @(negedge clk) rst = 1'b0;
      mode = MODE_OK;
      run_and_check("after_reset", 1'b0);
   endtask

   task automatic test_settle_one();
      int lat;
      logic [1:0] seq[$];
      mode = MODE_OK;
      lat = -1;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1;
      if (busy_s1) seq.push_back({in1_s1, in2_s1});
      @(negedge clk) start = 1'b0;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (busy_s1 && (seq.size() == 0 || seq[$] != {in1_s1, in2_s1})) seq.push_back({in1_s1, in2_s1});
         if (done_s1) lat = k;
      end
      n_checks++;
      if (lat != 8) begin n_fail++; $display("FAIL s1_latency: got %0d expected 8", lat); end
      n_checks++;
      if (seq.size() != 4 || seq[0] !== 2'd0 || seq[3] !== 2'd3) begin
         n_fail++; $display("FAIL s1_vectors: got %0d steps expected 00,01,10,11", seq.size());
      end
      n_checks++;
      if ({err_count_s1, pass_s1, err_valid_s1} !== {7'd0, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL s1_result: got cnt=%0d pass=%b valid=%b expected 0 1 0",
                            err_count_s1, pass_s1, err_valid_s1);
      end
      repeat (6) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean();
      test_beh_nor();
      test_gate_zero();
      test_random();
      test_start_held();
      test_reset_mid();
      test_settle_one();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
